// File: rtl/round_score_display.sv
// Round timer, win/fail tallies and best-time tracker for the teeter game,
// with an 8-digit multiplexed 7-segment display driver.
module round_score_display #(
  parameter int TICK_DIV = 1_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_new_game,
  input  logic        i_round_start,
  input  logic        i_playing,
  input  logic        i_win,
  input  logic        i_fail,
  output logic [15:0] o_time,
  output logic [7:0]  o_win_cnt,
  output logic [7:0]  o_fail_cnt,
  output logic [15:0] o_best_time,
  output logic        o_best_valid,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [7:0]  o_an
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] tick_cnt;
  logic          tick_hit;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic [3:0]    digit_val;

  function automatic logic [15:0] bcd4_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd2_inc_sat(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tick_hit   = (state == RUN) && i_playing && (tick_cnt == TW'(TICK_DIV - 1));
    if (i_new_game) begin
      next_state = IDLE;
    end else if (i_round_start) begin
      next_state = RUN;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        RUN:     next_state = (i_win || i_fail) ? DONE : RUN;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Round time, tallies and best time; a win or fail edge takes priority over a tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_new_game) begin
      tick_cnt     <= TW'(0);
      o_time       <= 16'h0000;
      o_win_cnt    <= 8'h00;
      o_fail_cnt   <= 8'h00;
      o_best_time  <= 16'h9999;
      o_best_valid <= 1'b0;
    end else if (i_round_start) begin
      tick_cnt <= TW'(0);
      o_time   <= 16'h0000;
    end else if (state == RUN && i_win) begin
      o_win_cnt <= bcd2_inc_sat(o_win_cnt);
      if (!o_best_valid || o_time < o_best_time) begin
        o_best_time  <= o_time;
        o_best_valid <= 1'b1;
      end
    end else if (state == RUN && i_fail) begin
      o_fail_cnt <= bcd2_inc_sat(o_fail_cnt);
    end else if (state == RUN && i_playing) begin
      if (tick_hit) begin
        tick_cnt <= TW'(0);
        o_time   <= bcd4_inc_sat(o_time);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scan_cnt <= SW'(0);
      digit    <= 3'd0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= SW'(0);
      digit    <= digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    digit_val = 4'd0;
    case (digit)
      3'd7:    digit_val = o_time[15:12];
      3'd6:    digit_val = o_time[11:8];
      3'd5:    digit_val = o_time[7:4];
      3'd4:    digit_val = o_time[3:0];
      3'd3:    digit_val = o_win_cnt[7:4];
      3'd2:    digit_val = o_win_cnt[3:0];
      3'd1:    digit_val = o_fail_cnt[7:4];
      3'd0:    digit_val = o_fail_cnt[3:0];
      default: digit_val = 4'd0;
    endcase
  end

  // Display pins lag the digit index by one cycle so anode and segments switch together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_an  <= 8'b1111_1110;
      o_seg <= 7'b1000000;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= ~(8'b0000_0001 << digit);
      o_seg <= seg7(digit_val);
      o_dp  <= (digit == 3'd6) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_round_score_display.sv
// Directed plus randomized checks of round_score_display against a
// cycle-level model that works in plain integer centiseconds and counts.
module tb_round_score_display;
  localparam int TD = 4;
  localparam int SD = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_new_game = 1'b0;
  logic        i_round_start = 1'b0;
  logic        i_playing = 1'b0;
  logic        i_win = 1'b0;
  logic        i_fail = 1'b0;
  logic [15:0] o_time;
  logic [7:0]  o_win_cnt;
  logic [7:0]  o_fail_cnt;
  logic [15:0] o_best_time;
  logic        o_best_valid;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [7:0]  o_an;

  int compared = 0;
  int mismatched = 0;

  // model: 0 idle, 1 run, 2 done; time and tallies as plain integers
  int         m_state, m_t, m_w, m_f, m_best, m_pc, m_scan, m_dig;
  bit         m_bv;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  round_score_display #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_new_game(i_new_game),
    .i_round_start(i_round_start), .i_playing(i_playing), .i_win(i_win),
    .i_fail(i_fail), .o_time(o_time), .o_win_cnt(o_win_cnt),
    .o_fail_cnt(o_fail_cnt), .o_best_time(o_best_time),
    .o_best_valid(o_best_valid), .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int digit_of(input int d);
    case (d)
      7: return m_t / 1000;
      6: return (m_t / 100) % 10;
      5: return (m_t / 10) % 10;
      4: return m_t % 10;
      3: return m_w / 10;
      2: return m_w % 10;
      1: return m_f / 10;
      default: return m_f % 10;
    endcase
  endfunction

  task automatic model_edge();
    logic [7:0] one;
    one = 8'h01;
    if (!i_rst_n) begin
      m_state = 0; m_t = 0; m_w = 0; m_f = 0; m_best = 9999; m_bv = 1'b0;
      m_pc = 0; m_scan = 0; m_dig = 0;
      m_an = 8'hFE; m_seg = 7'h40; m_dp = 1'b1;
    end else begin
      m_an  = ~(one << m_dig);
      m_seg = seg_tab[digit_of(m_dig)];
      m_dp  = (m_dig == 6) ? 1'b0 : 1'b1;
      m_scan++;
      m_dig = (m_scan / SD) % 8;
      if (i_new_game) begin
        m_state = 0; m_t = 0; m_w = 0; m_f = 0; m_best = 9999; m_bv = 1'b0; m_pc = 0;
      end else if (i_round_start) begin
        m_state = 1; m_t = 0; m_pc = 0;
      end else if (m_state == 1 && i_win) begin
        m_state = 2;
        if (m_w < 99) m_w++;
        if (!m_bv || m_t < m_best) begin
          m_best = m_t; m_bv = 1'b1;
        end
      end else if (m_state == 1 && i_fail) begin
        m_state = 2;
        if (m_f < 99) m_f++;
      end else if (m_state == 1 && i_playing) begin
        m_pc++;
        if (m_pc % TD == 0 && m_t < 9999) m_t++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("time", o_time, to_bcd4(m_t));
    chk("win_cnt", {8'h00, o_win_cnt}, {8'h00, to_bcd2(m_w)});
    chk("fail_cnt", {8'h00, o_fail_cnt}, {8'h00, to_bcd2(m_f)});
    chk("best_time", o_best_time, to_bcd4(m_best));
    chk("best_valid", {15'h0, o_best_valid}, {15'h0, m_bv});
    chk("an", {8'h00, o_an}, {8'h00, m_an});
    chk("seg", {9'h0, o_seg}, {9'h0, m_seg});
    chk("dp", {15'h0, o_dp}, {15'h0, m_dp});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_round(input int n, input bit w, input bit f);
    i_round_start = 1'b1; cycle(); i_round_start = 1'b0;
    run(n);
    i_win = w; i_fail = f; cycle(); i_win = 1'b0; i_fail = 1'b0;
  endtask

  initial begin
    run(3);
    chk("rst_an", {8'h00, o_an}, 16'h00FE);
    chk("rst_seg", {9'h0, o_seg}, 16'h0040);
    i_rst_n = 1'b1;
    run(20);

    i_playing = 1'b1;
    do_round(40, 1'b1, 1'b0);
    chk("r1_time", o_time, 16'h0010);
    chk("r1_win", {8'h00, o_win_cnt}, 16'h0001);
    chk("r1_best", o_best_time, 16'h0010);
    chk("r1_valid", {15'h0, o_best_valid}, 16'h0001);
    run(3);
    do_round(60, 1'b1, 1'b0);
    chk("r2_best", o_best_time, 16'h0010);
    do_round(28, 1'b1, 1'b0);
    chk("r3_best", o_best_time, 16'h0007);
    do_round(20, 1'b0, 1'b1);
    chk("fail_cnt1", {8'h00, o_fail_cnt}, 16'h0001);
    chk("fail_best", o_best_time, 16'h0007);

    i_round_start = 1'b1; cycle(); i_round_start = 1'b0;
    run(20);
    i_playing = 1'b0; run(100);
    chk("pause_time", o_time, 16'h0005);
    i_playing = 1'b1; run(40100);
    chk("sat_time", o_time, 16'h9999);
    i_win = 1'b1; cycle(); i_win = 1'b0;
    chk("sat_win4", {8'h00, o_win_cnt}, 16'h0004);

    for (int k = 0; k < 100; k++) do_round(0, 1'b1, 1'b0);
    chk("win_sat", {8'h00, o_win_cnt}, 16'h0099);

    i_new_game = 1'b1; cycle(); i_new_game = 1'b0;
    chk("ng_win", {8'h00, o_win_cnt}, 16'h0000);
    chk("ng_best", o_best_time, 16'h9999);

    do_round(8, 1'b1, 1'b1);
    chk("both_win", {8'h00, o_win_cnt}, 16'h0001);
    chk("both_fail", {8'h00, o_fail_cnt}, 16'h0000);
    i_fail = 1'b1; cycle(); i_fail = 1'b0;
    chk("done_fail", {8'h00, o_fail_cnt}, 16'h0000);
    i_round_start = 1'b1; i_win = 1'b1; cycle(); i_round_start = 1'b0; i_win = 1'b0;
    chk("rs_win_time", o_time, 16'h0000);
    run(8);
    chk("rs_win_run", o_time, 16'h0002);
    chk("rs_win_cnt", {8'h00, o_win_cnt}, 16'h0001);

    i_new_game = 1'b1; cycle(); i_new_game = 1'b0;
    run(8);
    chk("ng_idle_time", o_time, 16'h0000);
    chk("ng_valid", {15'h0, o_best_valid}, 16'h0000);

    i_round_start = 1'b1; cycle(); i_round_start = 1'b0;
    run(8);
    i_rst_n = 1'b0; cycle(); i_rst_n = 1'b1;
    run(8);
    chk("rst_mid_time", o_time, 16'h0000);

    for (int k = 0; k < 4000; k++) begin
      i_playing     = ($urandom_range(0, 9) != 0);
      i_round_start = ($urandom_range(0, 59) == 0);
      i_win         = ($urandom_range(0, 79) == 0);
      i_fail        = ($urandom_range(0, 79) == 0);
      i_new_game    = ($urandom_range(0, 1499) == 0);
      i_rst_n       = ($urandom_range(0, 1999) != 0);
      cycle();
    end
    i_rst_n = 1'b1; i_new_game = 1'b0; i_round_start = 1'b0;
    i_win = 1'b0; i_fail = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/round_score_display.md
# round_score_display

Scoring and timing stage downstream of the teeter game-control state machine. Consumes the round-start, playing, win and fail events that the game controller produces, and times each round in BCD seconds.centiseconds. Keeps win/fail tallies and the best winning time, and multiplexes time and tallies onto the board's 8-digit 7-segment display.

## Interface
Parameters:
- `TICK_DIV`, default 1_000_000: i_clk cycles per centisecond tick (100 MHz board clock); minimum 2.
- `SCAN_DIV`, default 100_000: i_clk cycles per display digit slot; minimum 2.

Ports:
- `i_clk` in 1: board clock. One clock domain.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_new_game` in 1: one-cycle pulse; clears tallies, best time and timer.
- `i_round_start` in 1: one-cycle pulse; the ball has been placed and play begins.
- `i_playing` in 1: level; the game is in its playing state.
- `i_win` in 1: one-cycle pulse; the ball entered the win hole.
- `i_fail` in 1: one-cycle pulse; the ball entered a fail hole.
- `o_time` out 16: current round time, BCD {s10,s1,c10,c1}.
- `o_win_cnt` out 8: BCD wins, 00–99.
- `o_fail_cnt` out 8: BCD fails, 00–99.
- `o_best_time` out 16: best winning time, BCD.
- `o_best_valid` out 1: o_best_time holds a real result.
- `o_seg` out 7: active-low segments {g,f,e,d,c,b,a}.
- `o_dp` out 1: active-low decimal point.
- `o_an` out 8: active-low digit anodes. Exactly one bit is low at any time.

## Operation
- State machine, three states:
  - IDLE → RUN on i_round_start.
  - RUN → DONE on i_win or i_fail.
  - DONE → RUN on i_round_start.
  - Any state → IDLE on i_new_game.
- Event priority, highest first: !i_rst_n, i_new_game, i_round_start, i_win, i_fail.
- i_round_start in any state clears o_time to 0000 and clears the tick divider.
- In RUN, the tick divider counts while i_playing=1 and holds while i_playing=0. On terminal count the divider wraps to 0 and o_time advances one centisecond as a BCD ripple: c1 → c10 → s1 → s10.
- o_time saturates at 9999 and holds there.
- i_win in RUN:
  - o_win_cnt increments, BCD, saturating at 99.
  - o_time freezes.
  - If !o_best_valid or o_time < o_best_time, then o_best_time ← o_time and o_best_valid ← 1.
- i_fail in RUN: o_fail_cnt increments, saturating at 99; o_time freezes.
- i_win and i_fail in the same cycle count as a win only.
- i_win and i_fail are ignored in IDLE and DONE.
- A tick coinciding with i_win is not applied; the registered time is the pre-tick value.
- i_new_game clears o_time, both tallies, o_best_time (to 9999) and o_best_valid, and enters IDLE.
- Display scan:
  - The digit index runs 0..7 and advances every SCAN_DIV cycles, wrapping 7 → 0.
  - Digit mapping: 7=s10, 6=s1, 5=c10, 4=c1, 3=win tens, 2=win units, 1=fail tens, 0=fail units.
  - o_dp is low only on digit 6.
  - Segment encoding for 0–9 is the standard hex-digit set. BCD values above 9 never occur.
  - The scan runs in every state and is unaffected by i_new_game.

## Timing
- Reset values when i_rst_n=0 at an i_clk edge:
  - state IDLE; o_time=0000; o_win_cnt=o_fail_cnt=00.
  - o_best_time=9999; o_best_valid=0.
  - digit index 0, so o_an=8'b1111_1110, o_seg=7'b1000000 (shows "0"), o_dp=1.
  - both dividers 0.
- Asserting reset mid-round discards the round; nothing is counted.
- All outputs are registered.
- Event latency: a tally, time or best-time change is visible one cycle after the event edge.
- Tick timing: the first tick after i_round_start lands exactly TICK_DIV cycles later, provided i_playing=1 throughout.
- o_an, o_seg and o_dp change in the same cycle, one cycle after the digit index update. There is no blanking.
- A display digit reflects a counter change within one scan slot plus one cycle.

## Test plan
- Reset and scan, TICK_DIV=4, SCAN_DIV=2: hold i_rst_n=0, then release → o_an=FE and o_seg=1000000. o_an then steps FD, FB, … 7F and back to FE every 2 cycles. o_dp is low only when o_an=BF.
- Round timing, TICK_DIV=4: i_round_start, then i_playing=1 for 40 cycles, then i_win → o_time=0010, o_win_cnt=01, o_best_time=0010, o_best_valid=1.
- Best-time rule: second round won at 0015 → best stays 0010. Third round won at 0007 → best becomes 0007. A fail round does not touch best; o_fail_cnt=01.
- Pause and saturation: i_playing=0 for 100 cycles mid-round → o_time unchanged. Force 10,000+ ticks → o_time holds 9999. 100 wins → o_win_cnt holds 99.
- Simultaneous and ignored events:
  - i_win and i_fail together in RUN → win only.
  - i_fail in DONE → no change.
  - i_round_start together with i_win → o_time=0000, state RUN, no win counted.
- Clear paths: i_new_game mid-RUN → all tallies 0, o_best_valid=0, state IDLE; the scan continues without interruption. i_rst_n=0 mid-RUN gives the same result.
